// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Direct-mapped branch target buffer with 2-bit saturating counters.
//   Fetch side: combinational prediction (taken + target) from PCF.
//   Execute side: branch/jump resolution, redirect PC, mispredict flag,
//   and a single table update per cycle on the rising clock edge.
//   Optional statistics counters are enabled by defining BPU_STATS_EN.
module branch_predict_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_BITS   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  // fetch stage
  input  logic [ADDR_WIDTH-1:0] PCF,
  output logic                  PredTakenF,
  output logic [ADDR_WIDTH-1:0] PredTargetF,
  // execute stage
  input  logic                  ValidE,
  input  logic                  BranchE,
  input  logic [1:0]            JumpE,
  input  logic [2:0]            BranchTypeE,
  input  logic                  ZeroE,
  input  logic [ADDR_WIDTH-1:0] PCE,
  input  logic [ADDR_WIDTH-1:0] PCTargetE,
  input  logic [ADDR_WIDTH-1:0] ALUResultE,
  input  logic [ADDR_WIDTH-1:0] PredTargetE,
  input  logic                  PredTakenE,
  output logic                  MispredictE,
  output logic [ADDR_WIDTH-1:0] RedirectPCE,
  output logic [1:0]            PCSrcE
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]           BranchCount,
  output logic [31:0]           MispredictCount
`endif
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = ADDR_WIDTH - IDX_BITS - 2;

  localparam logic [1:0] SRC_PC4 = 2'b00;
  localparam logic [1:0] SRC_IMM = 2'b01;
  localparam logic [1:0] SRC_ALU = 2'b10;

  // Counter saturation helpers
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // Table storage
  logic                  valid_q [ENTRIES];
  logic [TAG_W-1:0]      tag_q   [ENTRIES];
  logic [1:0]            ctr_q   [ENTRIES];
  logic [ADDR_WIDTH-1:0] tgt_q   [ENTRIES];

  // Fetch-side lookup fields
  logic [IDX_BITS-1:0] idx_f;
  logic [TAG_W-1:0]    tag_f;
  logic                hit_f;

  assign idx_f = PCF[IDX_BITS+1:2];
  assign tag_f = PCF[ADDR_WIDTH-1:IDX_BITS+2];

  // Fetch prediction; forced to zero while reset is held
  always_comb begin
    hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    PredTakenF  = ~rst & hit_f & ctr_q[idx_f][1];
    PredTargetF = (~rst & hit_f) ? tgt_q[idx_f] : '0;
  end

  // Execute-side resolution signals
  logic                  is_jal;
  logic                  is_jalr;
  logic                  br_cond;
  logic                  br_taken;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] pred_next;

  assign is_jal   = (JumpE == 2'b01);
  assign is_jalr  = (JumpE == 2'b10);
  assign pc_plus4 = PCE + ADDR_WIDTH'(4);

  // Branch condition by funct3: equal-style types take on Zero, others on !Zero
  always_comb begin
    br_cond = 1'b0;
    case (BranchTypeE)
      3'b000, 3'b101, 3'b111: br_cond = ZeroE;
      3'b001, 3'b100, 3'b110: br_cond = ~ZeroE;
      default:                br_cond = 1'b0;
    endcase
  end

  assign br_taken = BranchE & br_cond;

  // Next-PC source select; jumps take priority over branches
  always_comb begin
    PCSrcE = SRC_PC4;
    if (ValidE) begin
      if (is_jal)        PCSrcE = SRC_IMM;
      else if (is_jalr)  PCSrcE = SRC_ALU;
      else if (br_taken) PCSrcE = SRC_IMM;
    end
  end

  // Redirect PC and mispredict detection against the carried prediction
  always_comb begin
    case (PCSrcE)
      SRC_IMM: RedirectPCE = PCTargetE;
      SRC_ALU: RedirectPCE = ALUResultE;
      default: RedirectPCE = pc_plus4;
    endcase
    pred_next   = PredTakenE ? PredTargetE : pc_plus4;
    MispredictE = ValidE & (pred_next != RedirectPCE);
  end

  // Execute-side table update fields
  logic [IDX_BITS-1:0]   idx_e;
  logic [TAG_W-1:0]      tag_e;
  logic                  hit_e;
  logic                  upd_en;
  logic                  upd_taken;
  logic                  wr_en_d;
  logic                  ent_valid_d;
  logic [TAG_W-1:0]      ent_tag_d;
  logic [1:0]            ent_ctr_d;
  logic [ADDR_WIDTH-1:0] ent_tgt_d;

  assign idx_e     = PCE[IDX_BITS+1:2];
  assign tag_e     = PCE[ADDR_WIDTH-1:IDX_BITS+2];
  assign upd_en    = ValidE & (BranchE | is_jal) & ~is_jalr;
  assign upd_taken = is_jal | br_taken;

  // New contents for the indexed entry; JAL always forces strongly taken
  always_comb begin
    hit_e       = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    wr_en_d     = 1'b0;
    ent_valid_d = valid_q[idx_e];
    ent_tag_d   = tag_q[idx_e];
    ent_ctr_d   = ctr_q[idx_e];
    ent_tgt_d   = tgt_q[idx_e];
    if (upd_en) begin
      if (is_jal) begin
        wr_en_d     = 1'b1;
        ent_valid_d = 1'b1;
        ent_tag_d   = tag_e;
        ent_ctr_d   = 2'b11;
        ent_tgt_d   = PCTargetE;
      end else if (hit_e) begin
        wr_en_d = 1'b1;
        if (upd_taken) begin
          ent_ctr_d = sat_inc(ctr_q[idx_e]);
          ent_tgt_d = PCTargetE;
        end else begin
          ent_ctr_d = sat_dec(ctr_q[idx_e]);
        end
      end else if (upd_taken) begin
        wr_en_d     = 1'b1;
        ent_valid_d = 1'b1;
        ent_tag_d   = tag_e;
        ent_ctr_d   = 2'b10;
        ent_tgt_d   = PCTargetE;
      end
    end
  end

  // Table write; reset wins over any coinciding update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= 2'b00;
        tgt_q[i]   <= '0;
      end
    end else if (wr_en_d) begin
      valid_q[idx_e] <= ent_valid_d;
      tag_q[idx_e]   <= ent_tag_d;
      ctr_q[idx_e]   <= ent_ctr_d;
      tgt_q[idx_e]   <= ent_tgt_d;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] bcount_q, bcount_d;
  logic [31:0] mcount_q, mcount_d;

  // Statistics next-state: count qualifying updates and mispredict cycles
  always_comb begin
    bcount_d = upd_en ? bcount_q + 32'd1 : bcount_q;
    mcount_d = MispredictE ? mcount_q + 32'd1 : mcount_q;
  end

  // Statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcount_q <= '0;
      mcount_q <= '0;
    end else begin
      bcount_q <= bcount_d;
      mcount_q <= mcount_d;
    end
  end

  assign BranchCount     = bcount_q;
  assign MispredictCount = mcount_q;
`endif

  // Byte-offset bits are not part of index or tag
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{PCF[1:0], PCE[1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Testbench for branch_predict_unit: directed scenarios plus randomized
// traffic checked against a behavioural table model. Define BPU_STATS_EN
// to also check the statistics counters.
module tb_branch_predict_unit;
  localparam int AW = 32;
  localparam int IB = 6;
  localparam int N  = 1 << IB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] PCF = '0;
  logic          PredTakenF;
  logic [AW-1:0] PredTargetF;
  logic          ValidE = 1'b0, BranchE = 1'b0, ZeroE = 1'b0, PredTakenE = 1'b0;
  logic [1:0]    JumpE = 2'b00;
  logic [2:0]    BranchTypeE = 3'b000;
  logic [AW-1:0] PCE = '0, PCTargetE = '0, ALUResultE = '0, PredTargetE = '0;
  logic          MispredictE;
  logic [AW-1:0] RedirectPCE;
  logic [1:0]    PCSrcE;
`ifdef BPU_STATS_EN
  logic [31:0]   BranchCount, MispredictCount;
`endif

  always #5 clk = ~clk;

  branch_predict_unit #(.ADDR_WIDTH(AW), .IDX_BITS(IB)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .ValidE(ValidE), .BranchE(BranchE), .JumpE(JumpE), .BranchTypeE(BranchTypeE), .ZeroE(ZeroE),
    .PCE(PCE), .PCTargetE(PCTargetE), .ALUResultE(ALUResultE), .PredTargetE(PredTargetE),
    .PredTakenE(PredTakenE), .MispredictE(MispredictE), .RedirectPCE(RedirectPCE), .PCSrcE(PCSrcE)
`ifdef BPU_STATS_EN
    , .BranchCount(BranchCount), .MispredictCount(MispredictCount)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: one record per table slot, counter kept as an integer 0..3
  bit            m_valid [N];
  logic [AW-1:0] m_tag   [N];
  int            m_ctr   [N];
  logic [AW-1:0] m_tgt   [N];
  int            m_bc = 0;
  int            m_mc = 0;

  function automatic int slot(input logic [AW-1:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic logic [AW-1:0] tagof(input logic [AW-1:0] pc);
    return pc / (4 * N);
  endfunction

  function automatic bit m_hit(input logic [AW-1:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == tagof(pc));
  endfunction

  task automatic m_clear();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_ctr[i] = 0; m_tgt[i] = '0;
    end
    m_bc = 0; m_mc = 0;
  endtask

  // Branch outcome from the instruction semantics
  function automatic bit m_taken();
    if (JumpE == 2'b01 || JumpE == 2'b10) return 1;
    if (!BranchE) return 0;
    case (int'(BranchTypeE))
      0, 5, 7: return ZeroE;   // BEQ, BGE, BGEU
      1, 4, 6: return !ZeroE;  // BNE, BLT, BLTU
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_e(input bit v, input bit br, input logic [1:0] j, input logic [2:0] bt,
                       input bit z, input logic [AW-1:0] pc, input logic [AW-1:0] tg,
                       input logic [AW-1:0] alu, input bit ptk, input logic [AW-1:0] ptg);
    ValidE = v; BranchE = br; JumpE = j; BranchTypeE = bt; ZeroE = z;
    PCE = pc; PCTargetE = tg; ALUResultE = alu; PredTakenE = ptk; PredTargetE = ptg;
  endtask

  // One cycle: check combinational outputs against the model, clock, update model
  task automatic step(input string tag);
    int            s;
    bit            tk, qual;
    logic [1:0]    src;
    logic [AW-1:0] redir, pnext;
    bit            mis;
    #2;
    s  = slot(PCF);
    chk({tag, ".PredTakenF"}, PredTakenF, AW'(m_hit(PCF) && m_ctr[s] >= 2));
    chk({tag, ".PredTargetF"}, PredTargetF, m_hit(PCF) ? m_tgt[s] : '0);
    tk = m_taken();
    if (!ValidE)              src = 2'd0;
    else if (JumpE == 2'b01)  src = 2'd1;
    else if (JumpE == 2'b10)  src = 2'd2;
    else if (tk)              src = 2'd1;
    else                      src = 2'd0;
    redir = (src == 2'd1) ? PCTargetE : (src == 2'd2) ? ALUResultE : PCE + 32'd4;
    pnext = PredTakenE ? PredTargetE : PCE + 32'd4;
    mis   = ValidE && (pnext != redir);
    chk({tag, ".PCSrcE"}, PCSrcE, src);
    chk({tag, ".RedirectPCE"}, RedirectPCE, redir);
    chk({tag, ".MispredictE"}, MispredictE, mis);
`ifdef BPU_STATS_EN
    chk({tag, ".BranchCount"}, BranchCount, m_bc);
    chk({tag, ".MispredictCount"}, MispredictCount, m_mc);
`endif
    qual = ValidE && (BranchE || JumpE == 2'b01) && JumpE != 2'b10;
    @(posedge clk);
    s = slot(PCE);
    if (qual) begin
      if (JumpE == 2'b01) begin
        m_valid[s] = 1; m_tag[s] = tagof(PCE); m_ctr[s] = 3; m_tgt[s] = PCTargetE;
      end else if (m_hit(PCE)) begin
        if (tk) begin
          m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
          m_tgt[s] = PCTargetE;
        end else begin
          m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
        end
      end else if (tk) begin
        m_valid[s] = 1; m_tag[s] = tagof(PCE); m_ctr[s] = 2; m_tgt[s] = PCTargetE;
      end
      m_bc++;
    end
    if (mis) m_mc++;
    #1;
  endtask

  // Reset pulse spanning one rising edge; execute inputs left as they are
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, ".rst_PredTakenF"}, PredTakenF, 1'b0);
    chk({tag, ".rst_PredTargetF"}, PredTargetF, '0);
    @(posedge clk);
    #1;
    m_clear();
    chk({tag, ".rst_edge_PredTakenF"}, PredTakenF, 1'b0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [AW-1:0] pool [8];

  initial begin
    bit            ptk;
    logic [AW-1:0] pc, pf;
    int            r;
    pool[0] = 32'h100; pool[1] = 32'h1100; pool[2] = 32'h104; pool[3] = 32'h200;
    pool[4] = 32'h2100; pool[5] = 32'hFFFF_FFFC; pool[6] = 32'h3C; pool[7] = 32'h4100;
    m_clear();

    // Reset with fetch at 0x100
    PCF = 32'h100;
    do_reset("reset");
    step("idle0");

    // BEQ taken, not predicted: allocate, then predicted on next fetch
    set_e(1, 1, 2'b00, 3'b000, 1, 32'h100, 32'h140, 32'h0, 0, 32'h0);
    #2;
    chk("beq.MispredictE", MispredictE, 1'b1);
    chk("beq.RedirectPCE", RedirectPCE, 32'h140);
    chk("beq.PCSrcE", PCSrcE, 2'b01);
    step("beq");
    set_e(0, 0, 2'b00, 3'b000, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    #2;
    chk("beq_next.PredTakenF", PredTakenF, 1'b1);
    chk("beq_next.PredTargetF", PredTargetF, 32'h140);
    step("beq_next");

    // Saturation then decay
    for (int i = 0; i < 4; i++) begin
      set_e(1, 1, 2'b00, 3'b000, 1, 32'h100, 32'h140, 32'h0, 1, 32'h140);
      step("sat_up");
    end
    set_e(1, 1, 2'b00, 3'b000, 0, 32'h100, 32'h140, 32'h0, 1, 32'h140);
    step("sat_nt1");
    #2;
    chk("sat_nt1.PredTakenF", PredTakenF, 1'b1);
    for (int i = 0; i < 2; i++) step("sat_nt");
    set_e(0, 0, 2'b00, 3'b000, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    #2;
    chk("sat_low.PredTakenF", PredTakenF, 1'b0);
    step("sat_low");

    // JALR: redirect to ALU result, never written
    PCF = 32'h200;
    set_e(1, 0, 2'b10, 3'b000, 0, 32'h200, 32'h999, 32'h804, 0, 32'h0);
    #2;
    chk("jalr.PCSrcE", PCSrcE, 2'b10);
    chk("jalr.RedirectPCE", RedirectPCE, 32'h804);
    chk("jalr.MispredictE", MispredictE, 1'b1);
    step("jalr");
    set_e(0, 0, 2'b00, 3'b000, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    #2;
    chk("jalr_nowr.PredTakenF", PredTakenF, 1'b0);
    chk("jalr_nowr.PredTargetF", PredTargetF, 32'h0);
    step("jalr_nowr");

    // Aliasing: retrain 0x100, then probe 0x1100 at the same index
    PCF = 32'h1100;
    for (int i = 0; i < 2; i++) begin
      set_e(1, 1, 2'b00, 3'b001, 0, 32'h100, 32'h180, 32'h0, 0, 32'h0);
      step("alias_train");
    end
    set_e(1, 1, 2'b00, 3'b000, 0, 32'h1100, 32'h1180, 32'h0, 0, 32'h0);
    #2;
    chk("alias.PredTakenF", PredTakenF, 1'b0);
    chk("alias.PredTargetF", PredTargetF, 32'h0);
    step("alias_nt_miss");
    PCF = 32'h100;
    set_e(1, 1, 2'b00, 3'b000, 0, 32'hFFFF_FFFC, 32'h40, 32'h0, 0, 32'h0);
    #2;
    chk("alias_keep.PredTakenF", PredTakenF, 1'b1);
    chk("wrap.RedirectPCE", RedirectPCE, 32'h0);
    chk("wrap.MispredictE", MispredictE, 1'b0);
    step("wrap");

    // Read before write: not-taken update on the fetched entry, same cycle
    set_e(1, 1, 2'b00, 3'b000, 0, 32'h100, 32'h180, 32'h0, 1, 32'h180);
    step("rbw1");
    step("rbw2");

    // JAL forces strong taken; then reset lands on an update in flight
    PCF = 32'h500;
    set_e(1, 0, 2'b01, 3'b000, 0, 32'h3C, 32'h800, 32'h0, 0, 32'h0);
    step("jal");
    set_e(1, 1, 2'b00, 3'b000, 1, 32'h500, 32'h900, 32'h0, 0, 32'h0);
    do_reset("midrst");
    set_e(0, 0, 2'b00, 3'b000, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    #2;
    chk("midrst.PredTakenF", PredTakenF, 1'b0);
    step("midrst_after");

    // Randomized traffic over a small PC pool to force hits and aliasing
    for (int n = 0; n < 400; n++) begin
      pc = pool[$urandom_range(0, 7)];
      pf = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 7)] : pc;
      PCF = pf;
      r = $urandom_range(0, 9);
      JumpE = (r < 7) ? 2'b00 : (r < 9) ? 2'b01 : 2'b10;
      ValidE = ($urandom_range(0, 7) != 0);
      BranchE = (JumpE == 2'b00) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
      BranchTypeE = 3'($urandom_range(0, 7));
      ZeroE = 1'($urandom_range(0, 1));
      PCE = pc;
      PCTargetE = {$urandom_range(0, 255), 2'b00} & 32'h3FC;
      ALUResultE = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 1) begin
        ptk = m_hit(pc) && m_ctr[slot(pc)] >= 2;
        PredTakenE = ptk;
        PredTargetE = m_hit(pc) ? m_tgt[slot(pc)] : 32'h0;
      end else begin
        PredTakenE = 1'($urandom_range(0, 1));
        PredTargetE = {$urandom_range(0, 255), 2'b00} & 32'h3FC;
      end
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
      step("rnd");
    end

`ifdef BPU_STATS_EN
    // Three branches, two of them mispredicted
    set_e(0, 0, 2'b00, 3'b000, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    do_reset("stats");
    set_e(1, 1, 2'b00, 3'b000, 1, 32'h300, 32'h380, 32'h0, 0, 32'h0);
    step("stats_b1");
    set_e(1, 1, 2'b00, 3'b001, 1, 32'h304, 32'h390, 32'h0, 0, 32'h0);
    step("stats_b2");
    set_e(1, 1, 2'b00, 3'b000, 1, 32'h300, 32'h3A0, 32'h0, 0, 32'h0);
    step("stats_b3");
    set_e(0, 0, 2'b00, 3'b000, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    #2;
    chk("stats.BranchCount", BranchCount, 32'd3);
    chk("stats.MispredictCount", MispredictCount, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning the PC/target width.
REQ-002 SHALL have parameter IDX_BITS, default 6, meaning the table has 2^IDX_BITS entries.
REQ-003 SHALL have ports: clk  in  1  single clock; rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: PCF  in  ADDR_WIDTH  fetch PC; PredTakenF  out  1  predict taken; PredTargetF  out  ADDR_WIDTH  predicted target.
REQ-005 SHALL have ports: ValidE  in  1  real instr in execute; BranchE  in  1; JumpE  in  2 (01 JAL, 10 JALR); BranchTypeE  in  3 (funct3); ZeroE  in  1  ALU compare flag.
REQ-006 SHALL have ports: PCE, PCTargetE (PC+imm), ALUResultE (JALR target), PredTargetE  in  ADDR_WIDTH each; PredTakenE  in  1  prediction carried down the pipe.
REQ-007 SHALL have ports: MispredictE  out  1  flush request; RedirectPCE  out  ADDR_WIDTH  correct next PC; PCSrcE  out  2  00 PC+4, 01 PC+imm, 10 ALUResult.

Function
REQ-008 SHALL hold per entry: valid, tag PC[ADDR_WIDTH-1:IDX_BITS+2], 2-bit saturating counter, target; index PC[IDX_BITS+1:2].
REQ-009 SHALL drive PredTakenF = valid & tag match & counter[1], combinational from PCF; PredTargetF = entry target, or 0 on a miss.
REQ-010 SHALL resolve taken: JumpE=01/10 always; BranchE with type 000 or 101 or 111 taken when ZeroE=1; types 001, 100, 110 taken when ZeroE=0; other types not taken.
REQ-011 SHALL give JumpE priority over BranchE; PCSrcE = 01 for JAL/taken branch, 10 for JALR, else 00; PCSrcE = 00 when ValidE=0.
REQ-012 SHALL set RedirectPCE = PCTargetE (PCSrcE=01), ALUResultE (10), PCE+4 (00), with modulo-2^ADDR_WIDTH wrap.
REQ-013 SHALL compute the predicted next PC as PredTakenE ? PredTargetE : PCE+4, and assert MispredictE = ValidE & (predicted next PC != RedirectPCE), combinationally in the same cycle.
REQ-014 SHALL update the table on the clk rising edge only when ValidE & (BranchE | JumpE=01) & JumpE!=10; JALR never writes.
REQ-015 SHALL on a hit increment the counter, saturating at 11, when taken; decrement, saturating at 00, when not taken; write target PCTargetE when taken.
REQ-016 SHALL on a miss allocate (valid=1, new tag, target PCTargetE, counter 10) only when taken; a not-taken miss leaves the table unchanged.
REQ-017 SHALL set the counter to 11 for any JAL update.
REQ-018 SHALL read before write: a fetch hitting the index updated in the same cycle sees the pre-update entry.

Reset
REQ-019 SHALL on rst=1 asynchronously clear every valid bit, counter and target to 0; PredTakenF=0 and PredTargetF=0 while any reset is active.
REQ-020 SHALL suppress any table write coinciding with rst, including an update in flight when rst is asserted mid-operation.
REQ-021 SHALL keep MispredictE, RedirectPCE and PCSrcE purely combinational; they are not reset.

Configuration
REQ-022 SHALL, when macro BPU_STATS_EN is defined, add outputs BranchCount and MispredictCount (32 bits each), incremented per qualifying update and per MispredictE cycle respectively, wrapping at 2^32 and cleared by rst.
REQ-023 SHALL, without BPU_STATS_EN, omit both ports and their counters entirely, with all other behaviour identical.

Verification
REQ-024 SHALL cover reset: rst pulse, PCF=0x100 -> PredTakenF=0 and PredTargetF=0.
REQ-025 SHALL cover BEQ at PCE=0x100, ZeroE=1, PCTargetE=0x140, PredTakenE=0 -> MispredictE=1, RedirectPCE=0x140, PCSrcE=01; next cycle PCF=0x100 -> PredTakenF=1, PredTargetF=0x140.
REQ-026 SHALL cover saturation: four taken updates of 0x100, then one not-taken -> counter 10, PredTakenF=1; two more not-taken -> PredTakenF=0.
REQ-027 SHALL cover JALR at PCE=0x200, ALUResultE=0x804, PredTakenE=0 -> PCSrcE=10, RedirectPCE=0x804, MispredictE=1, with no table write.
REQ-028 SHALL cover aliasing and wrap: PCE=0x100 vs PCE=0x1100 at the same index -> tag miss, no false hit; PCE=0xFFFFFFFC not-taken -> RedirectPCE=0x0.
REQ-029 SHALL cover, with BPU_STATS_EN defined, three branches and two mispredicts -> BranchCount=3, MispredictCount=2.
